// File: rtl/fir_coef_ctrl.sv
// Coefficient bank controller: streams HALF signed words into a shadow bank and
// swaps it into the active bank on a sample boundary. Optional load timeout: FIR_COEF_TIMEOUT_EN.
module fir_coef_ctrl #(
  parameter int FIR_TAP     = 128,
  parameter int COEFF_WIDTH = 16,
  parameter int DIV         = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  input  logic [COEFF_WIDTH-1:0]                cfg_data,
  input  logic                                  cfg_last,
  input  logic                                  cfg_abort,
  output logic                                  sample_en,
  output logic [(FIR_TAP/2)*COEFF_WIDTH-1:0]    coeff_bus,
  output logic                                  swap_done,
  output logic                                  load_err,
  output logic                                  busy
);
  // state | meaning
  // IDLE  | no load in progress, active bank stable
  // LOAD  | collecting words into the shadow bank
  // PEND  | shadow complete, waiting for the next sample_en to swap
  localparam int HALF = FIR_TAP / 2;
  localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CW   = $clog2(DIV);

  if ((FIR_TAP % 2) != 0 || FIR_TAP < 2 || DIV < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("fir_coef_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PEND} state_t;

  state_t                             state, state_nxt;
  logic [CW-1:0]                      cnt;
  logic [IW-1:0]                      widx, cur_idx;
  logic [HALF-1:0][COEFF_WIDTH-1:0]   shadow, active;
  logic accept, is_final, bad_word, abort_act, timeout_hit;
  logic wr_go, err_go, swap_go;

  assign sample_en = (cnt == CW'(DIV - 1));
  assign accept    = cfg_valid & cfg_ready;
  // A word accepted in IDLE always starts a fresh load at index 0.
  assign cur_idx   = (state == S_IDLE) ? '0 : widx;
  assign is_final  = (cur_idx == IW'(HALF - 1));
  assign bad_word  = (cfg_last != is_final);
  assign abort_act = cfg_abort & (state != S_IDLE);
  assign coeff_bus = active;

`ifdef FIR_COEF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (state != S_LOAD || accept)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  assign timeout_hit = (state == S_LOAD) && !accept && (to_cnt == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_go     = 1'b0;
    err_go    = 1'b0;
    swap_go   = 1'b0;
    case (state)
      S_IDLE, S_LOAD: begin
        if (abort_act) begin
          state_nxt = S_IDLE;
        end else if (accept) begin
          if (bad_word) begin
            err_go    = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            wr_go     = 1'b1;
            state_nxt = is_final ? S_PEND : S_LOAD;
          end
        end else if (timeout_hit) begin
          err_go    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_PEND: begin
        if (abort_act) begin
          state_nxt = S_IDLE;
        end else if (sample_en) begin
          swap_go   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state != S_PEND);
    busy      = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      widx      <= '0;
      shadow    <= '0;
      active    <= '0;
      swap_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      cnt       <= sample_en ? '0 : cnt + 1'b1;
      swap_done <= swap_go;
      load_err  <= err_go;
      if (wr_go) begin
        shadow[cur_idx] <= cfg_data;
        widx            <= is_final ? '0 : cur_idx + 1'b1;
      end
      if (err_go) begin
        shadow <= '0;
        widx   <= '0;
      end
      if (abort_act)
        widx <= '0;
      if (swap_go)
        active <= shadow;
    end
  end

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Randomized bench for fir_coef_ctrl against a queue-based reference model,
// with literal checks on reset timing, swap, error and abort scenarios.
module tb_fir_coef_ctrl;
  localparam int FIR_TAP = 128;
  localparam int CWID    = 16;
  localparam int DIV     = 4;
  localparam int TIMEOUT = 255;
  localparam int HALF    = FIR_TAP / 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   cfg_valid = 1'b0;
  logic                   cfg_ready;
  logic [CWID-1:0]        cfg_data = '0;
  logic                   cfg_last = 1'b0;
  logic                   cfg_abort = 1'b0;
  logic                   sample_en;
  logic [HALF*CWID-1:0]   coeff_bus;
  logic                   swap_done;
  logic                   load_err;
  logic                   busy;

  fir_coef_ctrl #(.FIR_TAP(FIR_TAP), .COEFF_WIDTH(CWID), .DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .cfg_abort(cfg_abort),
    .sample_en(sample_en), .coeff_bus(coeff_bus), .swap_done(swap_done),
    .load_err(load_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_sd_seen = 0;
  int n_err_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 collecting, 2 complete and waiting for a sample boundary.
  logic [CWID-1:0] m_active[HALF];
  logic [CWID-1:0] m_q[$];
  int  m_mode = 0;
  int  m_phase = 0;
  int  m_idle = 0;
  bit  m_sd = 0;
  bit  m_err = 0;
  bit  m_started = 0;

  always @(posedge clk) begin
    bit se, acc, ab, sd, er;
    if (!rst_n) begin
      for (int i = 0; i < HALF; i++) m_active[i] = '0;
      m_q.delete();
      m_mode = 0; m_phase = 0; m_idle = 0; m_sd = 0; m_err = 0;
      m_started = 1;
    end else begin
      se  = (m_phase == DIV - 1);
      acc = cfg_valid && (m_mode != 2);
      ab  = cfg_abort && (m_mode != 0);
      sd  = 0;
      er  = 0;
      if (ab) begin
        m_mode = 0;
        m_q.delete();
      end else if (m_mode == 2) begin
        if (se) begin
          for (int i = 0; i < HALF; i++) m_active[i] = m_q[i];
          m_q.delete();
          m_mode = 0;
          sd = 1;
        end
      end else if (acc) begin
        if (m_mode == 0) m_q.delete();
        m_q.push_back(cfg_data);
        m_idle = 0;
        if (cfg_last != (m_q.size() == HALF)) begin
          er = 1;
          m_q.delete();
          m_mode = 0;
        end else begin
          m_mode = (m_q.size() == HALF) ? 2 : 1;
        end
      end
`ifdef FIR_COEF_TIMEOUT_EN
      else if (m_mode == 1) begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          er = 1;
          m_q.delete();
          m_mode = 0;
        end
      end
`endif
      m_phase = (m_phase + 1) % DIV;
      m_sd  = sd;
      m_err = er;
    end
  end

  function automatic logic [HALF*CWID-1:0] model_bus();
    logic [HALF*CWID-1:0] r;
    for (int i = 0; i < HALF; i++) r[i*CWID +: CWID] = m_active[i];
    return r;
  endfunction

  always @(negedge clk) begin
    logic [HALF*CWID-1:0] eb;
    if (m_started) begin
      chk("sample_en", 64'(sample_en), 64'(m_phase == DIV - 1));
      chk("cfg_ready", 64'(cfg_ready), 64'(m_mode != 2));
      chk("busy",      64'(busy),      64'(m_mode != 0));
      chk("swap_done", 64'(swap_done), 64'(m_sd));
      chk("load_err",  64'(load_err),  64'(m_err));
      eb = model_bus();
      n_cmp++;
      if (coeff_bus !== eb) begin
        n_bad++;
        $display("FAIL coeff_bus at %0t: got %h expected %h", $time, coeff_bus, eb);
      end
      if (swap_done === 1'b1) n_sd_seen++;
      if (load_err === 1'b1) n_err_seen++;
    end
  end

  logic [CWID-1:0] sent[HALF];

  task automatic cyc(input bit v, input logic [CWID-1:0] d, input bit l, input bit a);
    cfg_valid = v; cfg_data = d; cfg_last = l; cfg_abort = a;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic load(input int nw, input int last_at, input int abort_at,
                      input bit seq, input bit gaps);
    logic [CWID-1:0] d;
    for (int i = 0; i < nw; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) cyc(1'b0, CWID'($urandom), 1'b0, 1'b0);
      d = seq ? CWID'(i + 1) : CWID'($urandom);
      if (i < HALF) sent[i] = d;
      cyc(1'b1, d, (i == last_at), (i == abort_at));
    end
    cfg_valid = 1'b0; cfg_last = 1'b0; cfg_abort = 1'b0;
  endtask

  task automatic wait_swap(output bit ok);
    ok = 0;
    for (int k = 0; k < 3 * DIV; k++) begin
      if (swap_done === 1'b1) begin
        ok = 1;
        break;
      end
      cyc(1'b0, '0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] pat;
    bit ok;
    int e0, s0, kind, k;
    logic [CWID-1:0] prev63;

    // Reset and sample strobe timing
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      pat[n-1] = sample_en;
      @(posedge clk);
      #1;
    end
    chk("reset_sample_pattern", 64'(pat), 64'h888);
    chk("reset_coeff_zero", 64'(coeff_bus == '0), 64'd1);
    chk("reset_cfg_ready", 64'(cfg_ready), 64'd1);

    // Full sequential load and swap
    load(HALF, HALF - 1, -1, 1'b1, 1'b0);
    chk("pend_cfg_ready", 64'(cfg_ready), 64'd0);
    chk("pend_busy", 64'(busy), 64'd1);
    wait_swap(ok);
    chk("swap_seen", 64'(ok), 64'd1);
    chk("coeff63_after_swap", 64'(coeff_bus[63*CWID +: CWID]), 64'd64);
    chk("coeff0_after_swap", 64'(coeff_bus[0 +: CWID]), 64'd1);
    idle(2);

    // Early last -> error, bank unchanged, then a good load
    e0 = n_err_seen;
    load(10, 9, -1, 1'b0, 1'b0);
    idle(2);
    chk("early_last_err_count", 64'(n_err_seen - e0), 64'd1);
    chk("early_last_bank_kept", 64'(coeff_bus[63*CWID +: CWID]), 64'd64);
    load(HALF, HALF - 1, -1, 1'b0, 1'b1);
    wait_swap(ok);
    chk("reload_swap_seen", 64'(ok), 64'd1);
    chk("reload_coeff63", 64'(coeff_bus[63*CWID +: CWID]), 64'(sent[63]));
    idle(2);

    // Missing last on the final word
    load(HALF, -1, -1, 1'b0, 1'b0);
    chk("missing_last_err", 64'(load_err), 64'd1);
    chk("missing_last_idle", 64'(busy), 64'd0);
    idle(2);

    // Abort in PEND on the sample_en cycle
    prev63 = coeff_bus[63*CWID +: CWID];
    s0 = n_sd_seen;
    load(HALF, HALF - 1, -1, 1'b0, 1'b0);
    k = 0;
    while (m_phase != DIV - 1 && k < DIV) begin
      idle(1);
      k++;
    end
    chk("abort_on_sample_cycle", 64'(sample_en), 64'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("abort_pend_busy", 64'(busy), 64'd0);
    idle(2 * DIV);
    chk("abort_pend_no_swap", 64'(n_sd_seen - s0), 64'd0);
    chk("abort_pend_bank_kept", 64'(coeff_bus[63*CWID +: CWID]), 64'(prev63));

    // Long idle inside a load
    e0 = n_err_seen;
    load(5, -1, -1, 1'b0, 1'b0);
    idle(300);
`ifdef FIR_COEF_TIMEOUT_EN
    chk("timeout_err_count", 64'(n_err_seen - e0), 64'd1);
`else
    chk("no_timeout_err_count", 64'(n_err_seen - e0), 64'd0);
    chk("no_timeout_still_busy", 64'(busy), 64'd1);
`endif
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("abort_load_busy", 64'(busy), 64'd0);
    idle(2);

    // Reset in the middle of a load
    load(30, -1, -1, 1'b0, 1'b0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    chk("midload_reset_bank_zero", 64'(coeff_bus == '0), 64'd1);
    chk("midload_reset_busy", 64'(busy), 64'd0);
    idle(DIV);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1: begin
          load(HALF, HALF - 1, -1, 1'b0, 1'b1);
          wait_swap(ok);
          chk("rand_swap_seen", 64'(ok), 64'd1);
        end
        2: load($urandom_range(1, HALF - 1), -1, -1, 1'b0, 1'b1) ;
        3: load(HALF, -1, -1, 1'b0, 1'b1);
        4: begin
          if ($urandom_range(0, 1) == 1) cyc(1'b0, '0, 1'b0, 1'b1);
          load(HALF, HALF - 1, $urandom_range(0, HALF - 1), 1'b0, 1'b1);
        end
        default: begin
          load(HALF, HALF - 1, -1, 1'b0, 1'b0);
          idle($urandom_range(0, DIV));
          cyc(1'b0, '0, 1'b0, 1'b1);
        end
      endcase
      if (kind == 2) begin
        k = $urandom_range(0, HALF - 1);
        load(k + 1, k, -1, 1'b0, 1'b0);
      end
      idle(2 * DIV + 2);
    end
    if (busy === 1'b1) cyc(1'b0, '0, 1'b0, 1'b1);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
